dadda_ppam_2_2: RTL and testbench



---
 rtl/dadda_ppam_2_2_pkg.sv | 7 +
 rtl/dadda_ppam_2_2_fa.sv | 13 +
 rtl/dadda_ppam_2_2.sv | 222 ++++++++++++++++++++++
 tb/tb_dadda_ppam_2_2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dadda_ppam_2_2_pkg.sv
// Shared widths for the 8x8 PPAM(2x2) Dadda multiplier.
package dadda_ppam_2_2_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

endpackage

// File: rtl/dadda_ppam_2_2_fa.sv
// 1-bit full adder (3:2 counter) used throughout the Dadda tree.
module dadda_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/dadda_ppam_2_2.sv
// 8x8 unsigned approximate multiplier: Dadda tree (heights 6,4,3,2) over an exact
// partial-product array whose 2x2 LSB corner is replaced by a three-bit PPAM cell.
// The only deviation from A*B is -2 when A[1:0] = B[1:0] = 2'b11. Product registered once.
module dadda_ppam_2_2
   import dadda_ppam_2_2_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [OP_W-1:0]   A,
   input  logic [OP_W-1:0]   B,
   output logic [PROD_W-1:0] P
);

   // pp[i][j] = A[j] & B[i], weight 2^(i+j)
   logic [OP_W-1:0][OP_W-1:0] pp;
   logic                      q0, q1, q2;

   // Partial-product generation.
   always_comb begin
      for (int i = 0; i < OP_W; i++) begin
         pp[i] = A & {OP_W{B[i]}};
      end
   end

   // PPAM 2x2 cell: pp01 and pp10 are OR-merged, which loses 2 only when both are set
   // (that is exactly A[1:0] = B[1:0] = 2'b11).
   assign q0 = pp[0][0];
   assign q1 = pp[0][1] | pp[1][0];
   assign q2 = pp[1][1];

   // ---------------------------------------------------------------------------
   // Stage 0: initial column heights 1,1,3,4,5,6,7,8,7,6,5,4,3,2,1
   // ---------------------------------------------------------------------------
   logic [2:0] s0_2;
   logic [3:0] s0_3;
   logic [4:0] s0_4;
   logic [5:0] s0_5;
   logic [6:0] s0_6;
   logic [7:0] s0_7;
   logic [6:0] s0_8;
   logic [5:0] s0_9;
   logic [4:0] s0_10;
   logic [3:0] s0_11;
   logic [2:0] s0_12;
   logic [1:0] s0_13;
   logic       s0_14;

   assign s0_2  = {pp[2][0], pp[0][2], q2};
   assign s0_3  = {pp[3][0], pp[2][1], pp[1][2], pp[0][3]};
   assign s0_4  = {pp[4][0], pp[3][1], pp[2][2], pp[1][3], pp[0][4]};
   assign s0_5  = {pp[5][0], pp[4][1], pp[3][2], pp[2][3], pp[1][4], pp[0][5]};
   assign s0_6  = {pp[6][0], pp[5][1], pp[4][2], pp[3][3], pp[2][4], pp[1][5], pp[0][6]};
   assign s0_7  = {pp[7][0], pp[6][1], pp[5][2], pp[4][3], pp[3][4], pp[2][5], pp[1][6],
                   pp[0][7]};
   assign s0_8  = {pp[7][1], pp[6][2], pp[5][3], pp[4][4], pp[3][5], pp[2][6], pp[1][7]};
   assign s0_9  = {pp[7][2], pp[6][3], pp[5][4], pp[4][5], pp[3][6], pp[2][7]};
   assign s0_10 = {pp[7][3], pp[6][4], pp[5][5], pp[4][6], pp[3][7]};
   assign s0_11 = {pp[7][4], pp[6][5], pp[5][6], pp[4][7]};
   assign s0_12 = {pp[7][5], pp[6][6], pp[5][7]};
   assign s0_13 = {pp[7][6], pp[6][7]};
   assign s0_14 = pp[7][7];

   // ---------------------------------------------------------------------------
   // Stage 1: max height 8 -> 6. HA col6, FA+HA col7, FA+HA col8, FA col9.
   // Only columns 6..10 change; the rest pass through from stage 0.
   // ---------------------------------------------------------------------------
   logic [2:0][2:0]  f1_in;
   logic [2:0]       f1_s, f1_c, h1_s, h1_c;
   logic [10:6][5:0] s1;

   assign f1_in[0] = s0_7[2:0];
   assign f1_in[1] = s0_8[2:0];
   assign f1_in[2] = s0_9[2:0];

   for (genvar g = 0; g < 3; g++) begin : g_fa1
      dadda_fa u_fa (.a_i(f1_in[g][0]), .b_i(f1_in[g][1]), .c_i(f1_in[g][2]),
                     .s_o(f1_s[g]), .co_o(f1_c[g]));
   end

   assign h1_s[0] = s0_6[0] ^ s0_6[1];
   assign h1_c[0] = s0_6[0] & s0_6[1];
   assign h1_s[1] = s0_7[3] ^ s0_7[4];
   assign h1_c[1] = s0_7[3] & s0_7[4];
   assign h1_s[2] = s0_8[3] ^ s0_8[4];
   assign h1_c[2] = s0_8[3] & s0_8[4];

   assign s1[6]  = {s0_6[6:2], h1_s[0]};
   assign s1[7]  = {s0_7[7:5], h1_s[1], f1_s[0], h1_c[0]};
   assign s1[8]  = {s0_8[6:5], h1_s[2], f1_s[1], h1_c[1], f1_c[0]};
   assign s1[9]  = {s0_9[5:3], f1_s[2], h1_c[2], f1_c[1]};
   assign s1[10] = {s0_10, f1_c[2]};

   // ---------------------------------------------------------------------------
   // Stage 2: 6 -> 4. HA col4, FA+HA col5, 2 FA cols 6..10, FA col11.
   // FA k for k in 1..10 sits in column (k+11)/2.
   // ---------------------------------------------------------------------------
   logic [11:0][2:0] f2_in;
   logic [11:0]      f2_s, f2_c;
   logic [1:0]       h2_s, h2_c;
   logic [12:4][3:0] s2;

   assign f2_in[0]  = s0_5[2:0];
   assign f2_in[11] = s0_11[2:0];
   for (genvar k = 6; k <= 10; k++) begin : g_in2
      assign f2_in[2*k-11] = s1[k][2:0];
      assign f2_in[2*k-10] = s1[k][5:3];
   end

   for (genvar g = 0; g < 12; g++) begin : g_fa2
      dadda_fa u_fa (.a_i(f2_in[g][0]), .b_i(f2_in[g][1]), .c_i(f2_in[g][2]),
                     .s_o(f2_s[g]), .co_o(f2_c[g]));
   end

   assign h2_s[0] = s0_4[0] ^ s0_4[1];
   assign h2_c[0] = s0_4[0] & s0_4[1];
   assign h2_s[1] = s0_5[3] ^ s0_5[4];
   assign h2_c[1] = s0_5[3] & s0_5[4];

   assign s2[4]  = {s0_4[4:2], h2_s[0]};
   assign s2[5]  = {s0_5[5], h2_s[1], f2_s[0], h2_c[0]};
   assign s2[6]  = {f2_s[2], f2_s[1], h2_c[1], f2_c[0]};
   assign s2[7]  = {f2_s[4], f2_s[3], f2_c[2], f2_c[1]};
   assign s2[8]  = {f2_s[6], f2_s[5], f2_c[4], f2_c[3]};
   assign s2[9]  = {f2_s[8], f2_s[7], f2_c[6], f2_c[5]};
   assign s2[10] = {f2_s[10], f2_s[9], f2_c[8], f2_c[7]};
   assign s2[11] = {s0_11[3], f2_s[11], f2_c[10], f2_c[9]};
   assign s2[12] = {s0_12, f2_c[11]};

   // ---------------------------------------------------------------------------
   // Stage 3: 4 -> 3. HA col3, one FA in each of cols 4..12 (FA k in column k+4).
   // ---------------------------------------------------------------------------
   logic [8:0][2:0]  f3_in;
   logic [8:0]       f3_s, f3_c;
   logic             h3_s, h3_c;
   logic [13:3][2:0] s3;

   for (genvar k = 4; k <= 12; k++) begin : g_in3
      assign f3_in[k-4] = s2[k][2:0];
   end

   for (genvar g = 0; g < 9; g++) begin : g_fa3
      dadda_fa u_fa (.a_i(f3_in[g][0]), .b_i(f3_in[g][1]), .c_i(f3_in[g][2]),
                     .s_o(f3_s[g]), .co_o(f3_c[g]));
   end

   assign h3_s = s0_3[0] ^ s0_3[1];
   assign h3_c = s0_3[0] & s0_3[1];

   assign s3[3] = {s0_3[3:2], h3_s};
   assign s3[4] = {s2[4][3], f3_s[0], h3_c};
   for (genvar k = 5; k <= 12; k++) begin : g_out3
      assign s3[k] = {s2[k][3], f3_s[k-4], f3_c[k-5]};
   end
   assign s3[13] = {s0_13, f3_c[8]};

   // ---------------------------------------------------------------------------
   // Stage 4: 3 -> 2. HA col2, one FA in each of cols 3..13 (FA k in column k+3).
   // ---------------------------------------------------------------------------
   logic [10:0][2:0] f4_in;
   logic [10:0]      f4_s, f4_c;
   logic             h4_s, h4_c;
   logic [14:2][1:0] s4;

   for (genvar k = 3; k <= 13; k++) begin : g_in4
      assign f4_in[k-3] = s3[k];
   end

   for (genvar g = 0; g < 11; g++) begin : g_fa4
      dadda_fa u_fa (.a_i(f4_in[g][0]), .b_i(f4_in[g][1]), .c_i(f4_in[g][2]),
                     .s_o(f4_s[g]), .co_o(f4_c[g]));
   end

   assign h4_s = s0_2[0] ^ s0_2[1];
   assign h4_c = s0_2[0] & s0_2[1];

   assign s4[2] = {s0_2[2], h4_s};
   assign s4[3] = {f4_s[0], h4_c};
   for (genvar k = 4; k <= 13; k++) begin : g_out4
      assign s4[k] = {f4_s[k-3], f4_c[k-4]};
   end
   assign s4[14] = {s0_14, f4_c[10]};

   // ---------------------------------------------------------------------------
   // Final CPA and output register
   // ---------------------------------------------------------------------------
   logic [PROD_W-1:0] row_a, row_b, p_d, p_q;

   // Gather the two remaining rows; columns 0/1 only ever held one bit each.
   always_comb begin
      row_a    = '0;
      row_b    = '0;
      row_a[0] = q0;
      row_a[1] = q1;
      for (int k = 2; k <= 14; k++) begin
         row_a[k] = s4[k][0];
         row_b[k] = s4[k][1];
      end
   end

   // 16-bit ripple-carry adder; the carry beyond bit 15 is always zero and dropped.
   always_comb begin : cpa
      logic c;
      c   = 1'b0;
      p_d = '0;
      for (int k = 0; k < PROD_W; k++) begin
         p_d[k] = row_a[k] ^ row_b[k] ^ c;
         c      = (row_a[k] & row_b[k]) | (c & (row_a[k] ^ row_b[k]));
      end
   end

   // Product register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign P = p_q;

endmodule

// File: tb/tb_dadda_ppam_2_2.sv
// Self-checking bench for dadda_ppam_2_2: arithmetic reference model, per-cycle compare,
// hand-computed literal cases, exhaustive sweep and random error-metric run.
module tb_dadda_ppam_2_2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  A = 8'd255;
   logic [7:0]  B = 8'd255;
   logic [15:0] P;

   int checks = 0;
   int failures = 0;
   int phase = 0;        // 1 = exhaustive, 2 = random
   bit chk_en = 1'b0;

   dadda_ppam_2_2 dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .P(P));

   always #5 clk = ~clk;

   // Reference: exact product, minus 2 when both low bit pairs are 3.
   function automatic int unsigned approx(input int unsigned a, input int unsigned b);
      int unsigned prod;
      prod = a * b;
      if ((a % 4 == 3) && (b % 4 == 3)) prod = prod - 2;
      return prod;
   endfunction

   // One-cycle model pipeline, including asynchronous clear.
   int unsigned exp_p, exp_exact;
   int          exp_phase;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_p     <= 0;
         exp_exact <= 0;
         exp_phase <= 0;
      end else begin
         exp_p     <= approx(A, B);
         exp_exact <= A * B;
         exp_phase <= phase;
      end
   end

   // Per-cycle compare plus error statistics gathered from the DUT output.
   int  ex_err_cnt = 0, ex_max_err = 0;
   int  rnd_n = 0, rnd_err_cnt = 0, rnd_max_err = 0;
   real rnd_sum_abs = 0.0, rnd_sum_rel = 0.0;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            int err;
            checks++;
            if (P !== exp_p[15:0]) begin
               failures++;
               $display("FAIL cycle_cmp t=%0t A/B-> P=%0d expected=%0d", $time, P, exp_p);
            end
            err = int'(exp_exact) - int'(P);
            if (err < 0) err = -err;
            if (exp_phase == 1) begin
               if (err != 0) ex_err_cnt++;
               if (err > ex_max_err) ex_max_err = err;
            end else if (exp_phase == 2) begin
               rnd_n++;
               if (err != 0) rnd_err_cnt++;
               if (err > rnd_max_err) rnd_max_err = err;
               rnd_sum_abs += real'(err);
               if (exp_exact != 0) rnd_sum_rel += real'(err) / real'(exp_exact);
            end
         end
      end
   end

   task automatic check_val(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got=%0d required=%0d", name, act, req);
      end
   endtask

   // Apply a pair, then check the product one edge later against a literal.
   task automatic lit(input string name, input int unsigned a, input int unsigned b,
                      input int unsigned req);
      @(negedge clk);
      A = a[7:0];
      B = b[7:0];
      @(posedge clk);
      #1;
      check_val(name, P, req);
      check_val({"model_", name}, approx(a, b), req);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int unsigned lat_a[3] = '{3, 10, 255};
   int unsigned lat_b[3] = '{3, 10, 1};
   int unsigned lat_p[3] = '{7, 100, 255};

   initial begin
      // Reset held with A = B = 255.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check_val("reset_p0", P, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("reset_release_255x255", P, 65023);

      lit("approx_3x3", 3, 3, 7);
      lit("approx_7x11", 7, 11, 75);
      lit("exact_4x5", 4, 5, 20);
      lit("exact_2x3", 2, 3, 6);
      lit("exact_0x200", 0, 200, 0);
      lit("exact_128x128", 128, 128, 16384);
      lit("exact_254x255", 254, 255, 64770);

      // Back-to-back pairs: product follows one cycle later, every cycle.
      @(negedge clk);
      A = lat_a[0][7:0];
      B = lat_b[0][7:0];
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("latency_%0d", i), P, lat_p[i]);
         @(negedge clk);
         if (i < 2) begin
            A = lat_a[i+1][7:0];
            B = lat_b[i+1][7:0];
         end
      end

      // Mid-stream reset clears P immediately; inputs held across release.
      A = 8'd7;
      B = 8'd11;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midreset_clear", P, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("midreset_first", P, 75);

      // Exhaustive sweep.
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            @(negedge clk);
            A = a[7:0];
            B = b[7:0];
            phase = 1;
         end
      end
      @(negedge clk);
      phase = 0;
      @(negedge clk);
      check_val("exhaustive_err_count", ex_err_cnt, 4096);
      check_val("exhaustive_max_err", ex_max_err, 2);

      // Random pairs with error metrics.
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         A = 8'($urandom_range(0, 255));
         B = 8'($urandom_range(0, 255));
         phase = 2;
      end
      @(negedge clk);
      phase = 0;
      @(negedge clk);
      check_val("random_samples", rnd_n, 10000);
      check_val("random_max_err", rnd_max_err, 2);
      begin
         real er, med;
         er  = real'(rnd_err_cnt) / real'(rnd_n);
         med = rnd_sum_abs / real'(rnd_n);
         $display("metrics: ER=%f MED=%f MRED=%e MNED=%e", er, med,
                  rnd_sum_rel / real'(rnd_n), med / 65025.0);
         check_val("random_er_in_range", (er > 0.045 && er < 0.080) ? 1 : 0, 1);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
